id_ex_pipe_stage: RTL and testbench

//  Parametrised ID->EX pipeline stage for the five-stage pipeline. Registers operands,

---
 rtl/id_ex_pipe_stage.sv | 101 ++++++++++
 tb/tb_id_ex_pipe_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_stage.sv
// id_ex_pipe_stage: ID->EX pipeline register with valid/ready, flush and bubble insertion.
// Define ID_EX_SKID_EN for a one-entry skid buffer with registered id_ready.
module id_ex_pipe_stage #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5,
    parameter int EX_CTRL_W = 6,
    parameter int MEM_CTRL_W = 4,
    parameter int WB_CTRL_W = 3,
    parameter int IMM_W = 12,
    parameter logic [MEM_CTRL_W-1:0] MEM_CTRL_NOP = MEM_CTRL_W'(4'hC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [DATA_W-1:0]     id_r1out,
    input  logic [DATA_W-1:0]     id_r2out,
    input  logic [REG_AW-1:0]     id_wreg1,
    input  logic [REG_AW-1:0]     id_rs2,
    input  logic [EX_CTRL_W-1:0]  id_ex_ctrl,
    input  logic [MEM_CTRL_W-1:0] id_mem_ctrl,
    input  logic [WB_CTRL_W-1:0]  id_wb_ctrl,
    input  logic [IMM_W-1:0]      id_imm,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [DATA_W-1:0]     ex_r1out,
    output logic [DATA_W-1:0]     ex_r2out,
    output logic [REG_AW-1:0]     ex_wreg1,
    output logic [REG_AW-1:0]     ex_rs2,
    output logic [EX_CTRL_W-1:0]  ex_ex_ctrl,
    output logic [MEM_CTRL_W-1:0] ex_mem_ctrl,
    output logic [WB_CTRL_W-1:0]  ex_wb_ctrl,
    output logic [IMM_W-1:0]      ex_imm
);
    localparam int DW = 2*DATA_W + 2*REG_AW + IMM_W;
    localparam int CW = EX_CTRL_W + MEM_CTRL_W + WB_CTRL_W;
    localparam logic [CW-1:0] BUBBLE = {{EX_CTRL_W{1'b0}}, MEM_CTRL_NOP, {WB_CTRL_W{1'b0}}};

    logic [DW-1:0] id_d, main_d, nxt_d;
    logic [CW-1:0] id_c, main_c, nxt_c;
    logic accept, pop, load;

    assign id_d = {id_r1out, id_r2out, id_wreg1, id_rs2, id_imm};
    assign id_c = {id_ex_ctrl, id_mem_ctrl, id_wb_ctrl};
    assign {ex_r1out, ex_r2out, ex_wreg1, ex_rs2, ex_imm} = main_d;
    assign {ex_ex_ctrl, ex_mem_ctrl, ex_wb_ctrl} = main_c;
    assign accept = id_valid & id_ready;
    assign pop = ex_valid & ex_ready;

`ifdef ID_EX_SKID_EN
    logic          skid_valid;
    logic [DW-1:0] skid_d;
    logic [CW-1:0] skid_c;

    assign id_ready = !skid_valid;
    // A held skid beat always refills main first, keeping beats in order.
    assign load = (skid_valid & pop) | (accept & (!ex_valid | ex_ready));
    assign nxt_d = skid_valid ? skid_d : id_d;
    assign nxt_c = skid_valid ? skid_c : id_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_valid <= 1'b0;
            skid_d <= '0;
            skid_c <= '0;
        end else if (flush) begin
            skid_valid <= 1'b0;
        end else if (accept & ex_valid & !ex_ready) begin
            skid_valid <= 1'b1;
            skid_d <= id_d;
            skid_c <= id_c;
        end else if (pop) begin
            skid_valid <= 1'b0;
        end
    end
`else
    assign id_ready = !ex_valid | ex_ready;
    assign load = accept;
    assign nxt_d = id_d;
    assign nxt_c = id_c;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid <= 1'b0;
            main_d <= '0;
            main_c <= BUBBLE;
        end else if (flush) begin
            ex_valid <= 1'b0;
            main_c <= BUBBLE;
        end else if (load) begin
            ex_valid <= 1'b1;
            main_d <= nxt_d;
            main_c <= nxt_c;
        end else if (pop) begin
            ex_valid <= 1'b0;
            main_c <= BUBBLE;
        end
    end
endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// tb_id_ex_pipe_stage: directed table-driven bench for id_ex_pipe_stage, plus stall and reset sequences.
module tb_id_ex_pipe_stage;
    localparam logic [63:0] R2K = 64'hFFFF_0000_0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1, flush = 1'b0, id_valid = 1'b0, ex_ready = 1'b0;
    logic id_ready, ex_valid;
    logic [63:0] id_r1out = '0, id_r2out = '0, ex_r1out, ex_r2out;
    logic [4:0] id_wreg1 = '0, id_rs2 = '0, ex_wreg1, ex_rs2;
    logic [5:0] id_ex_ctrl = '0, ex_ex_ctrl;
    logic [3:0] id_mem_ctrl = '0, ex_mem_ctrl;
    logic [2:0] id_wb_ctrl = '0, ex_wb_ctrl;
    logic [11:0] id_imm = '0, ex_imm;
    int checks = 0, errors = 0;
    logic skid;

    always #5 clk = ~clk;

    id_ex_pipe_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_r1out(id_r1out), .id_r2out(id_r2out), .id_wreg1(id_wreg1), .id_rs2(id_rs2),
        .id_ex_ctrl(id_ex_ctrl), .id_mem_ctrl(id_mem_ctrl), .id_wb_ctrl(id_wb_ctrl), .id_imm(id_imm),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_r1out(ex_r1out), .ex_r2out(ex_r2out), .ex_wreg1(ex_wreg1), .ex_rs2(ex_rs2),
        .ex_ex_ctrl(ex_ex_ctrl), .ex_mem_ctrl(ex_mem_ctrl), .ex_wb_ctrl(ex_wb_ctrl), .ex_imm(ex_imm)
    );

    typedef struct {
        logic rst, fl, iv, er;
        logic [63:0] r1;
        logic [4:0] wr;
        logic [5:0] exc;
        logic [3:0] mc;
        logic [2:0] wbc;
        logic ev;
        logic [63:0] e_r1;
        logic [4:0] e_wr;
        logic [5:0] e_exc;
        logic [3:0] e_mc;
        logic [2:0] e_wbc;
    } vec_t;

    function automatic vec_t mk(logic rst, logic fl, logic iv, logic er, logic [63:0] r1, logic [4:0] wr,
                                logic [5:0] exc, logic [3:0] mc, logic [2:0] wbc, logic ev,
                                logic [63:0] e_r1, logic [4:0] e_wr, logic [5:0] e_exc, logic [3:0] e_mc,
                                logic [2:0] e_wbc);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.er = er; v.r1 = r1; v.wr = wr;
        v.exc = exc; v.mc = mc; v.wbc = wbc; v.ev = ev; v.e_r1 = e_r1; v.e_wr = e_wr;
        v.e_exc = e_exc; v.e_mc = e_mc; v.e_wbc = e_wbc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [63:0] r1, input logic [4:0] wr,
                         input logic [5:0] exc, input logic [3:0] mc, input logic [2:0] wbc);
        id_valid = iv; id_r1out = r1; id_r2out = r1 ^ R2K; id_wreg1 = wr; id_rs2 = wr ^ 5'h10;
        id_ex_ctrl = exc; id_mem_ctrl = mc; id_wb_ctrl = wbc; id_imm = r1[11:0];
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[17];

    initial begin
`ifdef ID_EX_SKID_EN
        skid = 1'b1;
`else
        skid = 1'b0;
`endif
        tbl[0]  = mk(1,0,0,0, 64'h0,    5'd0, 6'h00, 4'h0, 3'd0, 0, 64'h0,    5'd0, 6'h00, 4'hC, 3'd0);
        tbl[1]  = mk(1,0,0,0, 64'h0,    5'd0, 6'h00, 4'h0, 3'd0, 0, 64'h0,    5'd0, 6'h00, 4'hC, 3'd0);
        tbl[2]  = mk(0,0,1,1, 64'h1234, 5'd7, 6'h05, 4'h3, 3'd5, 1, 64'h1234, 5'd7, 6'h05, 4'h3, 3'd5);
        tbl[3]  = mk(0,0,1,1, 64'hA1,   5'd1, 6'h11, 4'h1, 3'd1, 1, 64'hA1,   5'd1, 6'h11, 4'h1, 3'd1);
        tbl[4]  = mk(0,0,1,1, 64'hB2,   5'd2, 6'h22, 4'h2, 3'd2, 1, 64'hB2,   5'd2, 6'h22, 4'h2, 3'd2);
        tbl[5]  = mk(0,0,1,1, 64'hC3,   5'd3, 6'h33, 4'h6, 3'd3, 1, 64'hC3,   5'd3, 6'h33, 4'h6, 3'd3);
        tbl[6]  = mk(0,0,0,1, 64'h0,    5'd0, 6'h00, 4'h0, 3'd0, 0, 64'hC3,   5'd3, 6'h00, 4'hC, 3'd0);
        tbl[7]  = mk(0,0,0,1, 64'h0,    5'd0, 6'h00, 4'h0, 3'd0, 0, 64'hC3,   5'd3, 6'h00, 4'hC, 3'd0);
        tbl[8]  = mk(0,0,1,0, 64'hD4,   5'd4, 6'h3F, 4'h9, 3'd7, 1, 64'hD4,   5'd4, 6'h3F, 4'h9, 3'd7);
        tbl[9]  = mk(0,0,0,0, 64'h0,    5'd0, 6'h00, 4'h0, 3'd0, 1, 64'hD4,   5'd4, 6'h3F, 4'h9, 3'd7);
        tbl[10] = mk(0,0,0,0, 64'h0,    5'd0, 6'h00, 4'h0, 3'd0, 1, 64'hD4,   5'd4, 6'h3F, 4'h9, 3'd7);
        tbl[11] = mk(0,0,0,0, 64'h0,    5'd0, 6'h00, 4'h0, 3'd0, 1, 64'hD4,   5'd4, 6'h3F, 4'h9, 3'd7);
        tbl[12] = mk(0,0,0,1, 64'h0,    5'd0, 6'h00, 4'h0, 3'd0, 0, 64'hD4,   5'd4, 6'h00, 4'hC, 3'd0);
        tbl[13] = mk(0,0,1,0, 64'hE5,   5'd5, 6'h01, 4'hA, 3'd4, 1, 64'hE5,   5'd5, 6'h01, 4'hA, 3'd4);
        tbl[14] = mk(0,1,1,1, 64'hF6,   5'd6, 6'h2A, 4'h5, 3'd6, 0, 64'hE5,   5'd5, 6'h00, 4'hC, 3'd0);
        tbl[15] = mk(0,0,0,1, 64'h0,    5'd0, 6'h00, 4'h0, 3'd0, 0, 64'hE5,   5'd5, 6'h00, 4'hC, 3'd0);
        tbl[16] = mk(1,0,1,1, 64'h77,   5'd9, 6'h07, 4'h7, 3'd7, 0, 64'h0,    5'd0, 6'h00, 4'hC, 3'd0);

        for (int i = 0; i < 17; i++) begin
            reset = tbl[i].rst; flush = tbl[i].fl; ex_ready = tbl[i].er;
            drive(tbl[i].iv, tbl[i].r1, tbl[i].wr, tbl[i].exc, tbl[i].mc, tbl[i].wbc);
            step();
            chk($sformatf("v%0d ex_valid", i), 64'(ex_valid), 64'(tbl[i].ev));
            chk($sformatf("v%0d ex_r1out", i), ex_r1out, tbl[i].e_r1);
            chk($sformatf("v%0d ex_r2out", i), ex_r2out, tbl[i].e_r1 == 0 ? 64'h0 : tbl[i].e_r1 ^ R2K);
            chk($sformatf("v%0d ex_wreg1", i), 64'(ex_wreg1), 64'(tbl[i].e_wr));
            chk($sformatf("v%0d ex_rs2", i), 64'(ex_rs2), tbl[i].e_wr == 0 ? 64'h0 : 64'(tbl[i].e_wr ^ 5'h10));
            chk($sformatf("v%0d ex_imm", i), 64'(ex_imm), 64'(tbl[i].e_r1[11:0]));
            chk($sformatf("v%0d ex_ex_ctrl", i), 64'(ex_ex_ctrl), 64'(tbl[i].e_exc));
            chk($sformatf("v%0d ex_mem_ctrl", i), 64'(ex_mem_ctrl), 64'(tbl[i].e_mc));
            chk($sformatf("v%0d ex_wb_ctrl", i), 64'(ex_wb_ctrl), 64'(tbl[i].e_wbc));
        end

        // Stall with a second beat offered: skid absorbs it, no-skid back-pressures.
        reset = 0; flush = 0; ex_ready = 1;
        drive(1, 64'h100, 5'd8, 6'h0A, 4'h2, 3'd1);
        step();
        chk("stall first beat", ex_r1out, 64'h100);
        ex_ready = 0;
        drive(1, 64'h200, 5'd9, 6'h0B, 4'h3, 3'd2);
        #1 chk("stall id_ready before", 64'(id_ready), 64'(skid));
        step();
        chk("stall hold r1", ex_r1out, 64'h100);
        chk("stall hold valid", 64'(ex_valid), 64'h1);
        chk("stall id_ready full", 64'(id_ready), 64'h0);
        drive(1, 64'h300, 5'd10, 6'h0C, 4'h4, 3'd3);
        step();
        step();
        chk("stall hold r1 late", ex_r1out, 64'h100);
        chk("stall hold ctrl", 64'(ex_ex_ctrl), 64'h0A);
        chk("stall id_ready late", 64'(id_ready), 64'h0);
        ex_ready = 1;
        drive(0, 64'h0, 5'd0, 6'h0, 4'h0, 3'd0);
        step();
        chk("release valid", 64'(ex_valid), 64'(skid));
        chk("release r1", ex_r1out, skid ? 64'h200 : 64'h100);
        chk("release mem_ctrl", 64'(ex_mem_ctrl), skid ? 64'h3 : 64'hC);
        step();
        chk("drain valid", 64'(ex_valid), 64'h0);
        chk("drain r1", ex_r1out, skid ? 64'h200 : 64'h100);

        // Reset in the middle of a stall with the skid (if built) holding a beat.
        drive(1, 64'h400, 5'd11, 6'h0D, 4'h5, 3'd4);
        step();
        ex_ready = 0;
        drive(1, 64'h500, 5'd12, 6'h0E, 4'h6, 3'd5);
        step();
        reset = 1;
        drive(0, 64'h0, 5'd0, 6'h0, 4'h0, 3'd0);
        step();
        chk("rst stall valid", 64'(ex_valid), 64'h0);
        chk("rst stall r1", ex_r1out, 64'h0);
        chk("rst stall mem_ctrl", 64'(ex_mem_ctrl), 64'hC);
        chk("rst stall id_ready", 64'(id_ready), 64'h1);
        reset = 0; ex_ready = 1;
        step();
        chk("post rst valid", 64'(ex_valid), 64'h0);
        chk("post rst r1", ex_r1out, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
